mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single main-memory request port between the instruction cache (IC) and data cache (DC).
//  Sequences one outstanding transaction at a time: arbitrate, issue, wait for response, route response.
//  Sits between the IC/DC miss ports and the memory controller. Flags hung transactions with a timeout.
// PARAMETERS
//  ADDRESS_LENGTH  30   word-address width on all ports
//  DATA_WIDTH      32   width of memory read/write data bus
//  PRIO_MODE       0    0 = round-robin; 1 = fixed priority, IC always wins
//  TIMEOUT_CYCLES  255  max cycles in ST_WAIT before abort; counter width $clog2(TIMEOUT_CYCLES+1)
// PORTS
//  i_clk            in   1               clock, all logic on posedge
//  i_rst_n          in   1               synchronous reset, active-low
//  i_ic_req         in   1               IC read request; level, held until o_ic_data_valid
//  i_ic_req_addr    in   ADDRESS_LENGTH  IC read address
//  o_ic_data_valid  out  1               1-cycle pulse: o_ic_bus carries IC read data
//  o_ic_bus         out  DATA_WIDTH      IC read data (= i_mem_bus)
//  i_dc_req         in   1               DC request; level, held until o_dc_data_valid
//  i_dc_we          in   1               DC request is a write
//  i_dc_req_addr    in   ADDRESS_LENGTH  DC address
//  i_dc_wdata       in   DATA_WIDTH      DC write data
//  o_dc_data_valid  out  1               1-cycle pulse: read data valid or write acknowledged
//  o_dc_bus         out  DATA_WIDTH      DC read data (= i_mem_bus)
//  o_mem_req_ready  out  1               request pending to memory
//  o_mem_req_addr   out  ADDRESS_LENGTH  latched request address
//  o_mem_we         out  1               latched write enable
//  o_mem_wdata      out  DATA_WIDTH      latched write data
//  i_mem_data_valid in   1               memory response, valid for exactly 1 cycle
//  i_mem_bus        in   DATA_WIDTH      memory read data
//  o_busy           out  1               state != ST_IDLE
//  o_err_timeout    out  1               1-cycle pulse on timeout abort
// BEHAVIOUR
//  Reset (i_rst_n=0 at posedge): state=ST_IDLE; owner=DC; last_grant=DC; timeout count=0.
//   Latched addr/we/wdata=0. All outputs 0; reset overrides everything and drops any in-flight transaction.
//  FSM states: ST_IDLE, ST_WAIT.
//  ST_IDLE: if any req, grant, latch owner/addr/we/wdata (IC grant forces we=0, wdata=0), then -> ST_WAIT.
//  Arbitration, PRIO_MODE=0: single requester wins; on tie, grant the one != last_grant.
//   last_grant updates on grant. First tie after reset goes to IC.
//  Arbitration, PRIO_MODE=1: IC wins whenever i_ic_req=1.
//  ST_WAIT: o_mem_req_ready = ~i_mem_data_valid (combinational drop on response cycle).
//   o_mem_req_addr/we/wdata stable for the whole of ST_WAIT.
//  Response: i_mem_data_valid in ST_WAIT pulses owner's o_*_data_valid same cycle (combinational).
//   After the response, -> ST_IDLE; the other requester's valid stays 0.
//  Latency: req seen cycle N -> o_mem_req_ready=1 from N+1; response cycle M -> ST_IDLE at M+1.
//   Earliest next grant is M+1, so there is one idle cycle minimum between transactions.
//  Requester dropping req during ST_WAIT: transaction still completes; response pulse still issued.
//  Timeout: counter clears on entry to ST_WAIT and increments each ST_WAIT cycle without a response.
//   When count==TIMEOUT_CYCLES and no response: o_err_timeout=1 and o_mem_req_ready=0 that cycle.
//   No data_valid to owner; -> ST_IDLE. Response and timeout on the same cycle: response wins, no error.
//  i_mem_data_valid in ST_IDLE (late/stray): ignored, no valid pulses, no state change.
//  o_ic_bus/o_dc_bus are don't-care when their valid is 0 (driven = i_mem_bus).
// TESTING
//  T1 reset: hold i_rst_n=0 with i_ic_req=1 -> o_mem_req_ready=0, o_busy=0, all valids 0; release -> grant next cycle.
//  T2 IC read: i_ic_req addr=0x100, memory answers 3 cycles later with 0xDEADBEEF.
//   -> o_mem_req_addr=0x100, o_mem_we=0, o_ic_data_valid pulse with o_ic_bus=0xDEADBEEF, o_dc_data_valid=0.
//  T3 round-robin: both req held continuously, PRIO_MODE=0 -> grant order IC,DC,IC,DC; DC write shows o_mem_we=1.
//  T4 fixed priority: PRIO_MODE=1, both req held for 4 transactions -> all 4 granted to IC, DC starved.
//  T5 timeout: TIMEOUT_CYCLES=4, DC req, memory silent -> o_err_timeout pulse 4 cycles after entering ST_WAIT.
//   No o_dc_data_valid; back in ST_IDLE next cycle; stray i_mem_data_valid afterwards ignored.
//  T6 mid-op reset: i_rst_n=0 during ST_WAIT then response arrives -> no valid pulse, state ST_IDLE, outputs 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter: shares one memory request port between IC and DC misses,
// one outstanding transaction at a time, with a hung-transaction timeout.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDRESS_LENGTH = 30,
  parameter int DATA_WIDTH     = 32,
  parameter int PRIO_MODE      = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_ic_req,
  input  logic [ADDRESS_LENGTH-1:0] i_ic_req_addr,
  output logic                      o_ic_data_valid,
  output logic [DATA_WIDTH-1:0]     o_ic_bus,
  input  logic                      i_dc_req,
  input  logic                      i_dc_we,
  input  logic [ADDRESS_LENGTH-1:0] i_dc_req_addr,
  input  logic [DATA_WIDTH-1:0]     i_dc_wdata,
  output logic                      o_dc_data_valid,
  output logic [DATA_WIDTH-1:0]     o_dc_bus,
  output logic                      o_mem_req_ready,
  output logic [ADDRESS_LENGTH-1:0] o_mem_req_addr,
  output logic                      o_mem_we,
  output logic [DATA_WIDTH-1:0]     o_mem_wdata,
  input  logic                      i_mem_data_valid,
  input  logic [DATA_WIDTH-1:0]     i_mem_bus,
  output logic                      o_busy,
  output logic                      o_err_timeout
);

  localparam int   CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic OWN_DC = 1'b0;
  localparam logic OWN_IC = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic                      owner_q, owner_d;
  logic                      last_grant_q, last_grant_d;
  logic [ADDRESS_LENGTH-1:0] addr_q, addr_d;
  logic                      we_q, we_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  logic grant_ic;
  logic rsp;
  logic tmo;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;

    // Round-robin ties go to whoever did not win last time.
    if (PRIO_MODE != 0) begin
      grant_ic = i_ic_req;
    end else begin
      grant_ic = i_ic_req & (~i_dc_req | (last_grant_q == OWN_DC));
    end

    rsp = (state_q == ST_WAIT) & i_mem_data_valid;
    tmo = (state_q == ST_WAIT) & ~i_mem_data_valid &
          (cnt_q == CNT_W'(TIMEOUT_CYCLES));

    case (state_q)
      ST_IDLE: begin
        if (i_ic_req | i_dc_req) begin
          state_d      = ST_WAIT;
          owner_d      = grant_ic ? OWN_IC : OWN_DC;
          last_grant_d = grant_ic ? OWN_IC : OWN_DC;
          addr_d       = grant_ic ? i_ic_req_addr : i_dc_req_addr;
          we_d         = ~grant_ic & i_dc_we;
          wdata_d      = grant_ic ? '0 : i_dc_wdata;
          cnt_d        = '0;
        end
      end
      ST_WAIT: begin
        if (rsp | tmo) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_DC;
      last_grant_q <= OWN_DC;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
    end
  end

  // Reset asserted mid-transaction masks the response immediately.
  assign o_mem_req_ready = i_rst_n & (state_q == ST_WAIT) & ~i_mem_data_valid & ~tmo;
  assign o_ic_data_valid = i_rst_n & rsp & (owner_q == OWN_IC);
  assign o_dc_data_valid = i_rst_n & rsp & (owner_q == OWN_DC);
  assign o_err_timeout   = i_rst_n & tmo;
  assign o_busy          = i_rst_n & (state_q == ST_WAIT);
  assign o_mem_req_addr  = addr_q;
  assign o_mem_we        = we_q;
  assign o_mem_wdata     = wdata_q;
  assign o_ic_bus        = i_mem_bus;
  assign o_dc_bus        = i_mem_bus;

endmodule

`default_nettype wire
